// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store master for a synchronous dmem with a 1-cycle read latency.
// Accepts byte/half/word loads and stores over a valid/ready handshake. It returns
// exactly one response per request. Sub-word stores use read-modify-write.
// Misaligned requests and the reserved size are rejected without touching memory.
// Ports:
//   clock, ctrl_reset_n             clock, synchronous active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_we, req_size, req_signed    op: store/load, 0=byte 1=half 2=word 3=reserved, sign-extend
//   req_addr, req_wdata             byte address, right-justified store data
//   rsp_valid, rsp_err, rsp_rdata   one-cycle response pulse, error flag, load data
//   mem_address, mem_data, mem_wren dmem write/read port (all registered)
//   mem_q                           dmem read data, valid the cycle after the address
module dmem_lsu #(
   parameter int ADDR_W = 12
) (
   input  logic              clock,
   input  logic              ctrl_reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W+1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [31:0]       rsp_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_data,
   output logic              mem_wren,
   input  logic [31:0]       mem_q
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD    = 3'd1,
      RWAIT = 3'd2,
      WR    = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t state, state_nx;

   // latched request fields
   logic        r_we, r_we_nx;
   logic [1:0]  r_size, r_size_nx;
   logic        r_signed, r_signed_nx;
   logic [1:0]  r_lane, r_lane_nx;
   logic [31:0] r_wdata, r_wdata_nx;

   logic [ADDR_W-1:0] address_nx;
   logic [31:0]       data_nx;
   logic              wren_nx;
   logic              valid_nx;
   logic              err_nx;
   logic [31:0]       rdata_nx;

   logic        req_bad;
   logic [4:0]  sh;
   logic [31:0] shifted;
   logic [31:0] lmask;
   logic [31:0] merged;
   logic [31:0] loaded;

   assign req_ready = (state == IDLE);

   assign req_bad = (req_size == 2'd3) ||
                    (req_size == 2'd1 && req_addr[0]) ||
                    (req_size == 2'd2 && req_addr[1:0] != 2'b00);

   // Lane handling: shift the word down so the target lane sits at bit 0 for loads,
   // and build a lane mask shifted up into place for the store merge.
   assign sh      = {r_lane, 3'b000};
   assign shifted = mem_q >> sh;

   always_comb begin
      lmask  = '1;
      loaded = mem_q;
      case (r_size)
         2'd0: begin
            lmask  = 32'h0000_00ff;
            loaded = {{24{r_signed & shifted[7]}}, shifted[7:0]};
         end
         2'd1: begin
            lmask  = 32'h0000_ffff;
            loaded = {{16{r_signed & shifted[15]}}, shifted[15:0]};
         end
         default: begin
            lmask  = '1;
            loaded = mem_q;
         end
      endcase
   end

   assign merged = (mem_q & ~(lmask << sh)) | ((r_wdata & lmask) << sh);

   always_comb begin
      state_nx    = state;
      r_we_nx     = r_we;
      r_size_nx   = r_size;
      r_signed_nx = r_signed;
      r_lane_nx   = r_lane;
      r_wdata_nx  = r_wdata;
      address_nx  = mem_address;
      data_nx     = mem_data;
      wren_nx     = 1'b0;
      valid_nx    = 1'b0;
      err_nx      = 1'b0;
      rdata_nx    = rsp_rdata;
      case (state)
         IDLE: begin
            if (req_valid) begin
               r_we_nx     = req_we;
               r_size_nx   = req_size;
               r_signed_nx = req_signed;
               r_lane_nx   = req_addr[1:0];
               r_wdata_nx  = req_wdata;
               if (req_bad) begin
                  valid_nx = 1'b1;
                  err_nx   = 1'b1;
                  rdata_nx = '0;
                  state_nx = DONE;
               end else begin
                  address_nx = req_addr[ADDR_W+1:2];
                  if (req_we && req_size == 2'd2) begin
                     data_nx  = req_wdata;
                     wren_nx  = 1'b1;
                     state_nx = WR;
                  end else begin
                     state_nx = RD;
                  end
               end
            end
         end
         RD: state_nx = RWAIT;
         RWAIT: begin
            if (r_we) begin
               data_nx  = merged;
               wren_nx  = 1'b1;
               state_nx = WR;
            end else begin
               rdata_nx = loaded;
               valid_nx = 1'b1;
               state_nx = DONE;
            end
         end
         WR: begin
            rdata_nx = '0;
            valid_nx = 1'b1;
            state_nx = DONE;
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!ctrl_reset_n) begin
         state       <= IDLE;
         r_we        <= 1'b0;
         r_size      <= '0;
         r_signed    <= 1'b0;
         r_lane      <= '0;
         r_wdata     <= '0;
         mem_address <= '0;
         mem_data    <= '0;
         mem_wren    <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_rdata   <= '0;
      end else begin
         state       <= state_nx;
         r_we        <= r_we_nx;
         r_size      <= r_size_nx;
         r_signed    <= r_signed_nx;
         r_lane      <= r_lane_nx;
         r_wdata     <= r_wdata_nx;
         mem_address <= address_nx;
         mem_data    <= data_nx;
         mem_wren    <= wren_nx;
         rsp_valid   <= valid_nx;
         rsp_err     <= err_nx;
         rsp_rdata   <= rdata_nx;
      end
   end

endmodule
